// File: rtl/uart_cmd_assembler_if.sv
// Handshake bundle between the UART RX/TX pair, cmd_proc and the command assembler.
// The assembler connects through the slave modport; its environment uses the master modport.
interface uart_cmd_assembler_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        rx_overrun;
    logic        resp_drop;
    logic        timeout_err;

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, tx_start, tx_data,
        output rx_overrun, resp_drop, timeout_err
    );

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, tx_start, tx_data,
        input  rx_overrun, resp_drop, timeout_err
    );
endinterface

// File: rtl/uart_cmd_assembler.sv
// Two-byte UART command assembler with inter-byte timeout, plus a response
// transmit path holding one active byte and a single-entry buffer.
module uart_cmd_assembler #(
    parameter logic [19:0] BYTE_TIMEOUT = 20'd500000
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_cmd_assembler_if.slave    bus
);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        WAIT_LOW  = 2'd1,
        CMD_HOLD  = 2'd2
    } rx_state_e;

    rx_state_e   rx_state_q, rx_state_d;
    logic [7:0]  high_q, high_d;
    logic [19:0] timer_q, timer_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        clr_rx_rdy_q, clr_rx_rdy_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        timeout_err_q, timeout_err_d;

    logic        tx_busy_q, tx_busy_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        resp_drop_q, resp_drop_d;

    // rx_rdy is still high during our clr_rx_rdy cycle, so it is masked there
    logic        rx_take_s;
    assign rx_take_s = bus.rx_rdy & ~clr_rx_rdy_q;

    // RX side: byte pairing, timeout supervision and cmd_proc handshake
    always_comb begin
        rx_state_d    = rx_state_q;
        high_d        = high_q;
        timer_d       = timer_q;
        cmd_d         = cmd_q;
        cmd_rdy_d     = cmd_rdy_q;
        clr_rx_rdy_d  = rx_take_s;
        rx_overrun_d  = 1'b0;
        timeout_err_d = 1'b0;
        case (rx_state_q)
            WAIT_HIGH: begin
                if (rx_take_s) begin
                    high_d     = bus.rx_data;
                    timer_d    = 20'd0;
                    rx_state_d = WAIT_LOW;
                end else begin
                    rx_state_d = WAIT_HIGH;
                end
            end
            WAIT_LOW: begin
                if (rx_take_s) begin
                    cmd_d      = {high_q, bus.rx_data};
                    cmd_rdy_d  = 1'b1;
                    timer_d    = 20'd0;
                    rx_state_d = CMD_HOLD;
                end else if (timer_q == (BYTE_TIMEOUT - 20'd1)) begin
                    // Lost low byte: drop the orphan high byte so the next pair realigns
                    timeout_err_d = 1'b1;
                    timer_d       = 20'd0;
                    rx_state_d    = WAIT_HIGH;
                end else begin
                    timer_d = timer_q + 20'd1;
                end
            end
            CMD_HOLD: begin
                if (bus.clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    if (rx_take_s) begin
                        high_d     = bus.rx_data;
                        timer_d    = 20'd0;
                        rx_state_d = WAIT_LOW;
                    end else begin
                        rx_state_d = WAIT_HIGH;
                    end
                end else if (rx_take_s) begin
                    rx_overrun_d = 1'b1;
                end else begin
                    rx_state_d = CMD_HOLD;
                end
            end
            default: begin
                rx_state_d = WAIT_HIGH;
                cmd_rdy_d  = 1'b0;
                timer_d    = 20'd0;
            end
        endcase
    end

    // TX side: active byte plus one buffered response
    always_comb begin
        tx_busy_d   = tx_busy_q;
        buf_full_d  = buf_full_q;
        buf_d       = buf_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        resp_drop_d = 1'b0;
        if (tx_busy_q) begin
            if (bus.tx_done) begin
                if (buf_full_q) begin
                    tx_data_d  = buf_q;
                    tx_start_d = 1'b1;
                    // The buffer frees this cycle, so a concurrent request refills it
                    if (bus.send_resp) begin
                        buf_d      = bus.resp;
                        buf_full_d = 1'b1;
                    end else begin
                        buf_full_d = 1'b0;
                    end
                end else if (bus.send_resp) begin
                    tx_data_d  = bus.resp;
                    tx_start_d = 1'b1;
                end else begin
                    tx_busy_d = 1'b0;
                end
            end else if (bus.send_resp) begin
                if (buf_full_q) begin
                    resp_drop_d = 1'b1;
                end else begin
                    buf_d      = bus.resp;
                    buf_full_d = 1'b1;
                end
            end else begin
                tx_busy_d = 1'b1;
            end
        end else if (bus.send_resp) begin
            tx_data_d  = bus.resp;
            tx_start_d = 1'b1;
            tx_busy_d  = 1'b1;
        end else begin
            tx_busy_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= WAIT_HIGH;
            high_q        <= 8'h00;
            timer_q       <= 20'd0;
            cmd_q         <= 16'h0000;
            cmd_rdy_q     <= 1'b0;
            clr_rx_rdy_q  <= 1'b0;
            rx_overrun_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            tx_busy_q     <= 1'b0;
            buf_full_q    <= 1'b0;
            buf_q         <= 8'h00;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            resp_drop_q   <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            high_q        <= high_d;
            timer_q       <= timer_d;
            cmd_q         <= cmd_d;
            cmd_rdy_q     <= cmd_rdy_d;
            clr_rx_rdy_q  <= clr_rx_rdy_d;
            rx_overrun_q  <= rx_overrun_d;
            timeout_err_q <= timeout_err_d;
            tx_busy_q     <= tx_busy_d;
            buf_full_q    <= buf_full_d;
            buf_q         <= buf_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            resp_drop_q   <= resp_drop_d;
        end
    end

    assign bus.clr_rx_rdy  = clr_rx_rdy_q;
    assign bus.cmd         = cmd_q;
    assign bus.cmd_rdy     = cmd_rdy_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.resp_drop   = resp_drop_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: command pairing, timeout, overrun,
// response queueing and reset recovery. Inputs change on the falling edge,
// outputs are checked on the falling edge.
module tb_uart_cmd_assembler;

    localparam logic [19:0] TO = 20'd200;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   n_clr, n_to, n_ovr, n_drop, n_start;
    int   snap_a, snap_b;
    logic rdy_a;

    uart_cmd_assembler_if bus();

    uart_cmd_assembler #(.BYTE_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled at the rising edge, before outputs update
    always @(posedge clk) begin
        if (bus.clr_rx_rdy)  n_clr   <= n_clr + 1;
        if (bus.timeout_err) n_to    <= n_to + 1;
        if (bus.rx_overrun)  n_ovr   <= n_ovr + 1;
        if (bus.resp_drop)   n_drop  <= n_drop + 1;
        if (bus.tx_start)    n_start <= n_start + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // rx_rdy stays high through the clr_rx_rdy cycle, like a real receiver
    task automatic rx_byte(input logic [7:0] b);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        cyc(1);
        chk("clr_rx_rdy_pulse", {31'd0, bus.clr_rx_rdy}, 32'd1);
        rdy_a = bus.cmd_rdy;
        cyc(1);
        chk("clr_rx_rdy_width", {31'd0, bus.clr_rx_rdy}, 32'd0);
        bus.rx_rdy = 1'b0;
    endtask

    task automatic clear_cmd(input string tag);
        bus.clr_cmd_rdy = 1'b1;
        cyc(1);
        bus.clr_cmd_rdy = 1'b0;
        chk(tag, {31'd0, bus.cmd_rdy}, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cmd"}, {16'd0, bus.cmd}, 32'd0);
        chk({tag, "_cmd_rdy"}, {31'd0, bus.cmd_rdy}, 32'd0);
        chk({tag, "_clr_rx"}, {31'd0, bus.clr_rx_rdy}, 32'd0);
        chk({tag, "_tx_start"}, {31'd0, bus.tx_start}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
        chk({tag, "_errs"}, {29'd0, bus.rx_overrun, bus.resp_drop, bus.timeout_err}, 32'd0);
    endtask

    task automatic tx_done_pulse();
        bus.tx_done = 1'b1;
        cyc(1);
        bus.tx_done = 1'b0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        n_clr = 0; n_to = 0; n_ovr = 0; n_drop = 0; n_start = 0;
        rdy_a = 1'b0;
        rst = 1'b1;
        bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b0; bus.resp = 8'h00; bus.tx_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        cyc(2);

        // T1: two bytes 100 clocks apart form one command
        snap_a = n_clr;
        rx_byte(8'h4B);
        cyc(100);
        rx_byte(8'hF4);
        chk("t1_rdy_latency", {31'd0, rdy_a}, 32'd1);
        chk("t1_cmd", {16'd0, bus.cmd}, 32'h4BF4);
        chk("t1_clr_count", n_clr - snap_a, 32'd2);
        chk("t1_rdy_held", {31'd0, bus.cmd_rdy}, 32'd1);
        clear_cmd("t1_cmd_rdy_clr");

        // T2: lost low byte times out once, next pair is aligned
        snap_a = n_to;
        rx_byte(8'h20);
        cyc(198);
        chk("t2_no_early_to", {31'd0, bus.timeout_err}, 32'd0);
        cyc(1);
        chk("t2_to_pulse", {31'd0, bus.timeout_err}, 32'd1);
        cyc(1);
        chk("t2_to_count", n_to - snap_a, 32'd1);
        rx_byte(8'h40);
        rx_byte(8'h01);
        chk("t2_rdy", {31'd0, rdy_a}, 32'd1);
        chk("t2_cmd", {16'd0, bus.cmd}, 32'h4001);
        clear_cmd("t2_clr");

        // T6: low byte on the exact timeout cycle wins
        snap_a = n_to;
        rx_byte(8'h77);
        cyc(198);
        rx_byte(8'h88);
        chk("t6_rdy", {31'd0, rdy_a}, 32'd1);
        chk("t6_cmd", {16'd0, bus.cmd}, 32'h7788);
        cyc(3);
        chk("t6_no_to", n_to - snap_a, 32'd0);
        clear_cmd("t6_clr");

        // T3: overrun while held, then clear and new high byte in the same cycle
        rx_byte(8'h4B);
        rx_byte(8'hF4);
        snap_a = n_ovr;
        rx_byte(8'h55);
        chk("t3_cmd_kept", {16'd0, bus.cmd}, 32'h4BF4);
        chk("t3_rdy_kept", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("t3_ovr_count", n_ovr - snap_a, 32'd1);
        bus.clr_cmd_rdy = 1'b1;
        rx_byte(8'h12);
        bus.clr_cmd_rdy = 1'b0;
        chk("t3_clr_honored", {31'd0, rdy_a}, 32'd0);
        rx_byte(8'h34);
        chk("t3_cmd", {16'd0, bus.cmd}, 32'h1234);
        chk("t3_ovr_once", n_ovr - snap_a, 32'd1);
        clear_cmd("t3_clr");

        // T4: A5 transmits, 5A buffers, FF is dropped
        snap_a = n_start; snap_b = n_drop;
        bus.send_resp = 1'b1; bus.resp = 8'hA5;
        cyc(1);
        chk("t4_start1", {31'd0, bus.tx_start}, 32'd1);
        chk("t4_data1", {24'd0, bus.tx_data}, 32'hA5);
        bus.resp = 8'h5A;
        cyc(1);
        chk("t4_start1_width", {31'd0, bus.tx_start}, 32'd0);
        bus.resp = 8'hFF;
        cyc(1);
        bus.send_resp = 1'b0;
        chk("t4_drop_pulse", {31'd0, bus.resp_drop}, 32'd1);
        cyc(5);
        chk("t4_data_stable", {24'd0, bus.tx_data}, 32'hA5);
        tx_done_pulse();
        chk("t4_start2", {31'd0, bus.tx_start}, 32'd1);
        chk("t4_data2", {24'd0, bus.tx_data}, 32'h5A);
        cyc(3);
        tx_done_pulse();
        cyc(3);
        chk("t4_start_count", n_start - snap_a, 32'd2);
        chk("t4_drop_count", n_drop - snap_b, 32'd1);

        // T4b: request coincident with tx_done and empty buffer goes straight out
        bus.send_resp = 1'b1; bus.resp = 8'h3C;
        cyc(1);
        bus.send_resp = 1'b0;
        chk("t4b_data", {24'd0, bus.tx_data}, 32'h3C);
        cyc(2);
        bus.tx_done = 1'b1; bus.send_resp = 1'b1; bus.resp = 8'hC3;
        cyc(1);
        bus.tx_done = 1'b0; bus.send_resp = 1'b0;
        chk("t4b_start", {31'd0, bus.tx_start}, 32'd1);
        chk("t4b_data2", {24'd0, bus.tx_data}, 32'hC3);
        cyc(2);
        tx_done_pulse();
        snap_a = n_start;
        tx_done_pulse();
        cyc(2);
        chk("t4b_idle_done_ignored", n_start - snap_a, 32'd0);

        // T5: reset mid-command and mid-transmit
        rx_byte(8'h11);
        bus.send_resp = 1'b1; bus.resp = 8'h99;
        cyc(1);
        bus.send_resp = 1'b0;
        rst = 1'b1;
        cyc(1);
        check_idle("t5_rst");
        rst = 1'b0;
        bus.send_resp = 1'b1; bus.resp = 8'h5A;
        cyc(1);
        bus.send_resp = 1'b0;
        chk("t5_tx_idle_start", {31'd0, bus.tx_start}, 32'd1);
        chk("t5_tx_idle_data", {24'd0, bus.tx_data}, 32'h5A);
        tx_done_pulse();
        rx_byte(8'h2F);
        rx_byte(8'hFF);
        chk("t5_cmd", {16'd0, bus.cmd}, 32'h2FFF);
        chk("t5_rdy", {31'd0, rdy_a}, 32'd1);
        clear_cmd("t5_clr");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
